addsub_seq_ctrl: RTL and testbench
==================================

ADDSUB_SEQ_CTRL -- requirements
Module: addsub_seq_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning the operand width in 4-bit nibbles (legal range 2..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning the operation request is valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts a request this cycle.
REQ-006 SHALL have port op_a, input, 4*NIBBLES, meaning operand A.
REQ-007 SHALL have port op_b, input, 4*NIBBLES, meaning operand B.
REQ-008 SHALL have port op_sub, input, 1, selecting A+B when 0 and A-B when 1.
REQ-009 SHALL have port adder_a, output, 4, the A nibble driven to the external 4-bit adder.
REQ-010 SHALL have port adder_b, output, 4, the B nibble (inverted for subtract) driven to the external adder.
REQ-011 SHALL have port adder_cin, output, 1, the carry-in to the external adder.
REQ-012 SHALL have port adder_q, input, 4, the combinational sum nibble from the external adder.
REQ-013 SHALL have port adder_cout, input, 1, the combinational carry-out from the external adder.
REQ-014 SHALL have port out_valid, output, 1, meaning result is valid.
REQ-015 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-016 SHALL have port result, output, 4*NIBBLES, meaning A+B or A-B modulo 2^(4*NIBBLES).
REQ-017 SHALL have port cout, output, 1, the final carry-out (for subtract: 1 = no borrow).

Function
REQ-018 SHALL implement states IDLE, RUN, DONE.
REQ-019 SHALL assert in_ready only in IDLE; handshake completes on an edge with in_valid and in_ready both 1.
REQ-020 SHALL, on accept, register op_a, op_b, op_sub, clear the nibble index to 0, and enter RUN.
REQ-021 SHALL, in RUN with index i, drive adder_a = A[4i+3:4i], adder_b = B nibble XOR {4{sub}}, adder_cin = sub when i=0 else the registered carry.
REQ-022 SHALL, at each RUN edge, store adder_q into result nibble i and adder_cout into the carry register, then increment i.
REQ-023 SHALL transition RUN -> DONE on the edge processing i = NIBBLES-1; out_valid rises NIBBLES+1 cycles after the accept edge.
REQ-024 SHALL hold out_valid, result, cout stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-025 SHALL ignore in_valid and op_* changes outside IDLE (no latching, no abort).
REQ-026 SHALL drive adder_a, adder_b, adder_cin to 0 outside RUN.
REQ-027 SHALL allow out_ready high before out_valid; the handshake completes on the first DONE cycle (one-cycle out_valid pulse).
REQ-028 SHALL ignore index wrap; index never exceeds NIBBLES-1.

Reset
REQ-029 SHALL, while rst=1, force state IDLE, index 0, carry 0, result 0, cout 0, out_valid 0, in_ready 0; in_ready rises in the first cycle after rst deasserts.
REQ-030 SHALL abort any in-progress RUN or DONE on reset with no result delivered.

Configuration
REQ-031 SHALL, with ADDSUB_SEQ_OVF_EN defined, add output ovf, 1 bit, valid with out_valid: signed two's-complement overflow = (A_msb ~^ Beff_msb) & (A_msb ^ result_msb), Beff = B XOR {sub}; reset value 0.
REQ-032 SHALL, without ADDSUB_SEQ_OVF_EN, omit the ovf port and its logic entirely.

Verification (NIBBLES=4, bench models external adder as ideal 4-bit add)
REQ-033 SHALL check 0x1234 + 0x0FFF, sub=0 -> result 0x2233, cout 0, out_valid 5 cycles after accept.
REQ-034 SHALL check 0xFFFF + 0x0001, sub=0 -> result 0x0000, cout 1, ovf 0 (full carry ripple across nibbles).
REQ-035 SHALL check 0x0000 - 0x0001, sub=1 -> result 0xFFFF, cout 0; 0x8000 - 0x0001 -> 0x7FFF, cout 1, ovf 1.
REQ-036 SHALL check out_ready held 0 for 10 cycles in DONE -> result/out_valid stable, in_ready 0, new in_valid ignored.
REQ-037 SHALL check rst pulsed during RUN index 2 -> next cycle all outputs at reset values, no out_valid; following request computes correctly.
REQ-038 SHALL check back-to-back requests with out_ready tied 1 -> one result per NIBBLES+2 cycles, operand capture only in IDLE.

Source files
------------

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial add/subtract sequencer that drives an external 4-bit adder, one nibble per cycle.
// Optional signed-overflow output is enabled by defining ADDSUB_SEQ_OVF_EN.
module addsub_seq_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   op_sub,
    output logic [3:0]             adder_a,
    output logic [3:0]             adder_b,
    output logic                   adder_cin,
    input  logic [3:0]             adder_q,
    input  logic                   adder_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   result,
`ifdef ADDSUB_SEQ_OVF_EN
    output logic                   ovf,
`endif
    output logic                   cout
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LastIdx = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sub_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_q      <= op_a;
                        b_q      <= op_b;
                        sub_q    <= op_sub;
                        idx_q    <= '0;
                        in_ready <= 1'b0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    result[4*idx_q +: 4] <= adder_q;
                    carry_q              <= adder_cout;
                    if (idx_q == LastIdx) begin
                        cout      <= adder_cout;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
`ifdef ADDSUB_SEQ_OVF_EN
                        // Operands of equal effective sign producing a result of the other sign
                        ovf <= (a_q[W-1] ~^ (b_q[W-1] ^ sub_q)) & (a_q[W-1] ^ adder_q[3]);
`endif
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Subtract is A + ~B + 1: invert B per nibble and inject the +1 as carry-in on nibble 0
    always_comb begin
        adder_a   = 4'h0;
        adder_b   = 4'h0;
        adder_cin = 1'b0;
        if (state_q == StRun) begin
            adder_a   = a_q[4*idx_q +: 4];
            adder_b   = b_q[4*idx_q +: 4] ^ {4{sub_q}};
            adder_cin = (idx_q == '0) ? sub_q : carry_q;
        end
    end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Scoreboard bench for addsub_seq_ctrl with an ideal external 4-bit adder; checks ovf when
// ADDSUB_SEQ_OVF_EN is defined.
module tb_addsub_seq_ctrl;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         op_sub = 1'b0;
    logic [3:0]   adder_a, adder_b, adder_q;
    logic         adder_cin, adder_cout;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         cout;
`ifdef ADDSUB_SEQ_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    logic [4:0] adder_sum;
    assign adder_sum  = {1'b0, adder_a} + {1'b0, adder_b} + {4'b0, adder_cin};
    assign adder_q    = adder_sum[3:0];
    assign adder_cout = adder_sum[4];

    addsub_seq_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .adder_a   (adder_a),
        .adder_b   (adder_b),
        .adder_cin (adder_cin),
        .adder_q   (adder_q),
        .adder_cout(adder_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
`ifdef ADDSUB_SEQ_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W-1:0] beff;
        logic [W:0]   s;
        exp_t         e;
        beff = b ^ {W{sub}};
        s    = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, sub};
        e.res = s[W-1:0];
        e.co  = s[W];
        e.ov  = (a[W-1] ~^ beff[W-1]) & (a[W-1] ^ e.res[W-1]);
        return e;
    endfunction

    // Returns at the negedge of the first cycle after the accept edge; operands are scrambled.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output bit ok);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!in_ready) begin
            $display("FAIL send_in_ready: in_ready=%b, required 1 within 20 cycles", in_ready);
            ok = 1'b0;
            return;
        end
        n_pass++;
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_sub   = sub;
        sb.push_back(model(a, b, sub));
        @(negedge clk);
        in_valid = 1'b0;
        op_a     = 16'($urandom);
        op_b     = 16'($urandom);
        op_sub   = 1'($urandom);
        ok       = 1'b1;
    endtask

    // Cycle 1 is the cycle right after the accept edge.
    task automatic wait_out(input int start, output int lat, output bit ok);
        lat = start;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ok = out_valid;
        if (!ok) begin
            n_checks++;
            $display("FAIL out_valid_timeout: out_valid=%b, required 1 within 40 cycles", out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, result, cout, adder_a, adder_b, adder_cin} !== '0)
            $display("FAIL reset_values: in_ready=%b out_valid=%b result=%h cout=%b a=%h b=%h cin=%b, required all 0",
                     in_ready, out_valid, result, cout, adder_a, adder_b, adder_cin);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_add();
        bit ok, ok2;
        int lat;
        exp_t e;
        out_ready = 1'b1;
        send(16'h1234, 16'h0FFF, 1'b0, ok);
        if (ok) begin
            n_checks++;
            if ({adder_a, adder_b, adder_cin, in_ready} !== {4'h4, 4'hF, 1'b0, 1'b0})
                $display("FAIL add_nibble0: a=%h b=%h cin=%b in_ready=%b, required 4 f 0 0",
                         adder_a, adder_b, adder_cin, in_ready);
            else n_pass++;
            wait_out(1, lat, ok2);
            if (ok2) begin
                e = sb.pop_front();
                n_checks++;
                if ({result, cout} !== {e.res, e.co} || lat != N + 1)
                    $display("FAIL add_result: result=%h cout=%b latency=%0d, required %h %b %0d",
                             result, cout, lat, e.res, e.co, N + 1);
                else n_pass++;
                @(negedge clk);
                n_checks++;
                if ({out_valid, in_ready} !== 2'b01)
                    $display("FAIL add_pulse: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
                else n_pass++;
            end
        end
        sb.delete();
    endtask

    task automatic test_carry();
        bit ok, ok2;
        int lat;
        exp_t e;
        out_ready = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, ok);
        if (ok) begin
            @(negedge clk);
            n_checks++;
            if ({adder_a, adder_b, adder_cin} !== {4'hF, 4'h0, 1'b1})
                $display("FAIL carry_nibble1: a=%h b=%h cin=%b, required f 0 1", adder_a, adder_b, adder_cin);
            else n_pass++;
            wait_out(2, lat, ok2);
            if (ok2) begin
                e = sb.pop_front();
                n_checks++;
                if ({result, cout} !== {e.res, e.co} || lat != N + 1)
                    $display("FAIL carry_result: result=%h cout=%b latency=%0d, required %h %b %0d",
                             result, cout, lat, e.res, e.co, N + 1);
                else n_pass++;
`ifdef ADDSUB_SEQ_OVF_EN
                n_checks++;
                if (ovf !== e.ov) $display("FAIL carry_ovf: ovf=%b, required %b", ovf, e.ov);
                else n_pass++;
`endif
                @(negedge clk);
            end
        end
        sb.delete();
    endtask

    task automatic test_sub();
        logic [W-1:0] ta [2] = '{16'h0000, 16'h8000};
        logic [W-1:0] tb [2] = '{16'h0001, 16'h0001};
        bit ok, ok2;
        int lat;
        exp_t e;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            send(ta[k], tb[k], 1'b1, ok);
            if (!ok) break;
            n_checks++;
            if ({adder_b, adder_cin} !== {4'hE, 1'b1})
                $display("FAIL sub_nibble0[%0d]: b=%h cin=%b, required e 1", k, adder_b, adder_cin);
            else n_pass++;
            wait_out(1, lat, ok2);
            if (!ok2) break;
            e = sb.pop_front();
            n_checks++;
            if ({result, cout} !== {e.res, e.co})
                $display("FAIL sub_result[%0d]: result=%h cout=%b, required %h %b",
                         k, result, cout, e.res, e.co);
            else n_pass++;
`ifdef ADDSUB_SEQ_OVF_EN
            n_checks++;
            if (ovf !== e.ov) $display("FAIL sub_ovf[%0d]: ovf=%b, required %b", k, ovf, e.ov);
            else n_pass++;
`endif
            @(negedge clk);
        end
        sb.delete();
    endtask

    task automatic test_stall();
        bit ok, ok2;
        int lat;
        int bad = 0;
        exp_t e;
        out_ready = 1'b0;
        send(16'hABCD, 16'h1111, 1'b1, ok);
        if (ok) begin
            wait_out(1, lat, ok2);
            if (ok2) begin
                e = sb.pop_front();
                for (int c = 0; c < 10; c++) begin
                    in_valid = 1'b1;
                    op_a     = 16'($urandom);
                    op_b     = 16'($urandom);
                    @(negedge clk);
                    if ({out_valid, in_ready, result, cout} !== {1'b1, 1'b0, e.res, e.co}) bad++;
                end
                n_checks++;
                if (bad != 0)
                    $display("FAIL stall_hold: %0d unstable cycles, last out_valid=%b in_ready=%b result=%h cout=%b, required 1 0 %h %b",
                             bad, out_valid, in_ready, result, cout, e.res, e.co);
                else n_pass++;
                in_valid  = 1'b0;
                out_ready = 1'b1;
                @(negedge clk);
                n_checks++;
                if ({out_valid, in_ready} !== 2'b01)
                    $display("FAIL stall_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
                else n_pass++;
            end
        end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        bit ok, ok2;
        int lat;
        int spurious = 0;
        exp_t e;
        out_ready = 1'b1;
        send(16'h5678, 16'h1234, 1'b0, ok);
        if (ok) begin
            repeat (2) @(negedge clk);
            n_checks++;
            if (adder_a !== 4'h6) $display("FAIL mid_index2: adder_a=%h, required 6", adder_a);
            else n_pass++;
            rst = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({in_ready, out_valid, result, cout, adder_a, adder_b, adder_cin} !== '0)
                $display("FAIL mid_reset_values: in_ready=%b out_valid=%b result=%h cout=%b a=%h b=%h cin=%b, required all 0",
                         in_ready, out_valid, result, cout, adder_a, adder_b, adder_cin);
            else n_pass++;
            rst = 1'b0;
            sb.delete();
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (out_valid) spurious++;
            end
            n_checks++;
            if (spurious != 0) $display("FAIL mid_no_result: out_valid high %0d cycles, required 0", spurious);
            else n_pass++;
            send(16'h0F0F, 16'h00F1, 1'b0, ok);
            if (ok) begin
                wait_out(1, lat, ok2);
                if (ok2) begin
                    e = sb.pop_front();
                    n_checks++;
                    if ({result, cout} !== {e.res, e.co} || lat != N + 1)
                        $display("FAIL mid_after: result=%h cout=%b latency=%0d, required %h %b %0d",
                                 result, cout, lat, e.res, e.co, N + 1);
                    else n_pass++;
                    @(negedge clk);
                end
            end
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int last_t = -1;
        logic [W-1:0] a, b;
        logic s;
        exp_t e;
        out_ready = 1'b1;
        for (int t = 0; t < 80 && got < 4; t++) begin
            if (out_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL b2b_unexpected: result=%h with nothing outstanding", result);
                end else begin
                    e = sb.pop_front();
                    if ({result, cout} !== {e.res, e.co})
                        $display("FAIL b2b_result[%0d]: result=%h cout=%b, required %h %b",
                                 got, result, cout, e.res, e.co);
                    else n_pass++;
                end
                if (last_t >= 0) begin
                    n_checks++;
                    if (t - last_t != N + 2)
                        $display("FAIL b2b_period[%0d]: %0d cycles, required %0d", got, t - last_t, N + 2);
                    else n_pass++;
                end
                last_t = t;
                got++;
            end
            if (in_ready && sent < 4) begin
                a = 16'($urandom);
                b = 16'($urandom);
                s = 1'($urandom);
                in_valid = 1'b1;
                op_a     = a;
                op_b     = b;
                op_sub   = s;
                sb.push_back(model(a, b, s));
                sent++;
            end else begin
                in_valid = 1'b0;
                op_a     = 16'($urandom);
                op_b     = 16'($urandom);
                op_sub   = 1'($urandom);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (got != 4) $display("FAIL b2b_count: %0d results, required 4", got);
        else n_pass++;
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_sub();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
